// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode encodings and FSM state type for the
// registered ALU pipeline (alu_pipe) and its shift-add multiplier.
//   OP_*     : 3-bit opcode values presented on s_opcode.
//   state_t  : alu_pipe control states (IDLE accepts, MUL iterates,
//              HOLD presents a result until the consumer takes it).
package alu_pipe_pkg;

  localparam logic [2:0] OP_NULL = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_pipe_seq_multiplier.sv
// seq_multiplier: unsigned WIDTH x WIDTH shift-add multiplier, one
// iteration per clock, WIDTH iterations per product.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : load a/b (ignored while busy)
//   a, b     : multiplicand, multiplier
//   busy     : iterations still outstanding
//   done     : one-cycle pulse; prod holds the finished product
//   prod     : {high partial, low partial}; final product once done
module seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;

  logic             load;
  logic [WIDTH-1:0] step_mcand;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   sum;

  assign load = start & ~busy;

  // The first iteration is folded into the load edge, working directly on
  // the incoming operands. That way the product is complete one edge
  // earlier and the parent can register it on the WIDTH-th edge after
  // accepting the op.
  always_comb begin
    step_mcand = load ? a : mcand;
    step_hi    = load ? '0 : hi;
    step_lo    = load ? b : lo;
    sum        = {1'b0, step_hi} + (step_lo[0] ? {1'b0, step_mcand} : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        mcand <= a;
        hi    <= sum[WIDTH:1];
        lo    <= {sum[0], b[WIDTH-1:1]};
        cnt   <= CNT_W'(1);
        busy  <= 1'b1;
      end else if (busy) begin
        // shift {carry, hi, lo} right by one
        hi  <= sum[WIDTH:1];
        lo  <= {sum[0], lo[WIDTH-1:1]};
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod = {hi, lo};

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with accumulator and multi-cycle MUL.
// One op in flight at a time.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, in_a, in_b, s_opcode, s_use_acc : op input channel
//   out_valid/out_ready, out_result, out_prod_hi, out_zero : result channel
//   dbg_state    : current control state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready is high only in IDLE; out_valid is high only in HOLD and
// stays high, with its data stable, until the edge that sees out_ready.
// Inputs presented while in_ready is low are not sampled.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         s_opcode,
  input  logic               s_use_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_result,
  output logic [WIDTH-1:0]   out_prod_hi,
  output logic               out_zero,
  output logic [1:0]         dbg_state
);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH:0]     alu_res;
  logic               accept;
  logic               alu_load;
  logic               mul_start;
  logic               mul_load;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     result_q;
  logic [WIDTH-1:0]   prod_hi_q;
  logic               zero_q;
  logic               valid_q;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign op_a      = s_use_acc ? acc : in_a;
  assign mul_start = accept & is_mul(s_opcode);
  assign alu_load  = accept & ~is_mul(s_opcode);
  assign mul_load  = (state == ST_MUL) & mul_done & ~mul_busy;

  // Single-cycle operations. SUB wraps in WIDTH+1 bits, so bit WIDTH is the
  // borrow (set exactly when opA < in_b).
  always_comb begin
    alu_res = {1'b0, op_a};
    case (s_opcode)
      OP_NULL: alu_res = {1'b0, op_a};
      OP_ADD:  alu_res = {1'b0, op_a} + {1'b0, in_b};
      OP_SUB:  alu_res = {1'b0, op_a} - {1'b0, in_b};
      OP_AND:  alu_res = {1'b0, op_a & in_b};
      OP_OR:   alu_res = {1'b0, op_a | in_b};
      OP_XOR:  alu_res = {1'b0, op_a ^ in_b};
      OP_NOT:  alu_res = {1'b0, ~op_a};
      default: alu_res = {1'b0, op_a};
    endcase
  end

  seq_multiplier #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (op_a),
    .b     (in_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mul_start)     state_nxt = ST_MUL;
        else if (alu_load) state_nxt = ST_HOLD;
      end
      ST_MUL: begin
        if (mul_load) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers and accumulator. The accumulator follows every result
  // as it enters HOLD, whether or not the consumer has taken it yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      prod_hi_q <= '0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
      acc       <= '0;
    end else if (alu_load) begin
      result_q  <= alu_res;
      prod_hi_q <= '0;
      zero_q    <= (alu_res[WIDTH-1:0] == '0);
      valid_q   <= 1'b1;
      acc       <= alu_res[WIDTH-1:0];
    end else if (mul_load) begin
      result_q  <= {1'b0, mul_prod[WIDTH-1:0]};
      prod_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
      zero_q    <= (mul_prod[WIDTH-1:0] == '0);
      valid_q   <= 1'b1;
      acc       <= mul_prod[WIDTH-1:0];
    end else if ((state == ST_HOLD) && out_ready) begin
      valid_q   <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_prod_hi = prod_hi_q;
  assign out_zero    = zero_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH = 8).
// Directed vector table with hand-derived expectations, a reset-mid-MUL
// sequence, then random ops checked against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int WIDTH = 8;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2:0]         s_opcode;
  logic               s_use_acc;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     out_result;
  logic [WIDTH-1:0]   out_prod_hi;
  logic               out_zero;
  logic [1:0]         dbg_state;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .s_opcode    (s_opcode),
    .s_use_acc   (s_use_acc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_prod_hi (out_prod_hi),
    .out_zero    (out_zero),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  int vectors     = 0;
  int miscompares = 0;
  int model_acc   = 0;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ua;
    int               bp;
    logic [WIDTH:0]   res;
    logic [WIDTH-1:0] hi;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int res, output int hi);
    int m;
    m   = 1 << WIDTH;
    hi  = 0;
    res = a;
    case (op)
      0: res = a;
      1: res = a + b;
      2: res = (a - b + 2 * m) % (2 * m);
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = (m - 1) - a;
      7: begin res = (a * b) % m; hi = (a * b) / m; end
      default: res = a;
    endcase
  endfunction

  // driver: one op from accept to release, with bp cycles of backpressure
  task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic ua, input int bp,
                       input logic [WIDTH:0] e_res, input logic [WIDTH-1:0] e_hi);
    int n;
    bit rdy_hi;
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid  = 1'b1;
    s_opcode  = op;
    in_a      = a;
    in_b      = b;
    s_use_acc = ua;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_a      = WIDTH'($urandom);
    in_b      = WIDTH'($urandom);
    s_opcode  = 3'($urandom);
    s_use_acc = 1'($urandom_range(0, 1));
    n = 1;
    rdy_hi = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_hi = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (in_ready) rdy_hi = 1'b1;
    chk("latency", n, (op == OP_MUL) ? WIDTH + 1 : 1);
    chk("in_ready_busy", int'(rdy_hi), 0);
    if (out_valid) begin
      chk("result", int'(out_result), int'(e_res));
      chk("prod_hi", int'(out_prod_hi), int'(e_hi));
      chk("zero", int'(out_zero), int'(e_res[WIDTH-1:0] == '0));
      for (int i = 0; i < bp; i++) begin
        // a competing op while holding must be ignored
        in_valid = 1'b1;
        s_opcode = OP_ADD;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom_range(1, 255));
        @(posedge clk); #1;
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_result", int'(out_result), int'(e_res));
        chk("hold_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", int'(out_valid), 0);
      chk("release_ready", int'(in_ready), 1);
    end
    model_acc = int'(e_res[WIDTH-1:0]);
  endtask

  initial begin
    int r;
    int h;
    int ea;
    bit saw_valid;
    logic [2:0]       rop;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rua;

    //            op       a      b      ua   bp  res      hi
    tbl[0]  = '{OP_NULL, 8'h55, 8'h00, 1'b1, 0, 9'h000, 8'h00};
    tbl[1]  = '{OP_ADD,  8'd200, 8'd100, 1'b0, 0, 9'h12C, 8'h00};
    tbl[2]  = '{OP_NULL, 8'h00, 8'h00, 1'b1, 0, 9'h02C, 8'h00};
    tbl[3]  = '{OP_SUB,  8'd5,  8'd7,  1'b0, 0, 9'h1FE, 8'h00};
    tbl[4]  = '{OP_SUB,  8'd9,  8'd9,  1'b0, 0, 9'h000, 8'h00};
    tbl[5]  = '{OP_MUL,  8'hFF, 8'hFF, 1'b0, 0, 9'h001, 8'hFE};
    tbl[6]  = '{OP_ADD,  8'd10, 8'd20, 1'b0, 0, 9'h01E, 8'h00};
    tbl[7]  = '{OP_ADD,  8'h77, 8'd5,  1'b1, 0, 9'h023, 8'h00};
    tbl[8]  = '{OP_NOT,  8'h00, 8'h5A, 1'b1, 0, 9'h0DC, 8'h00};
    tbl[9]  = '{OP_XOR,  8'hF0, 8'h3C, 1'b0, 5, 9'h0CC, 8'h00};
    tbl[10] = '{OP_MUL,  8'h00, 8'hAB, 1'b0, 1, 9'h000, 8'h00};
    tbl[11] = '{OP_AND,  8'hF0, 8'h3C, 1'b0, 0, 9'h030, 8'h00};
    tbl[12] = '{OP_OR,   8'hF0, 8'h3C, 1'b0, 0, 9'h0FC, 8'h00};
    tbl[13] = '{OP_MUL,  8'h11, 8'd3,  1'b1, 0, 9'h0F4, 8'h02};
    tbl[14] = '{OP_ADD,  8'h00, 8'h0C, 1'b1, 0, 9'h100, 8'h00};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    s_opcode  = OP_NULL;
    s_use_acc = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(out_result), 0);
    chk("rst_prod_hi", int'(out_prod_hi), 0);
    chk("rst_zero", int'(out_zero), 1);
    chk("rst_state", int'(dbg_state), int'(ST_IDLE));

    // directed table
    for (int i = 0; i < 15; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ua, tbl[i].bp,
            tbl[i].res, tbl[i].hi);

    // reset in the middle of a MUL
    in_valid  = 1'b1;
    s_opcode  = OP_MUL;
    in_a      = 8'hFF;
    in_b      = 8'hFF;
    s_use_acc = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_mul_ready", int'(in_ready), 0);
    chk("mid_mul_valid", int'(out_valid), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mulrst_in_ready", int'(in_ready), 1);
    chk("mulrst_valid", int'(out_valid), 0);
    chk("mulrst_result", int'(out_result), 0);
    chk("mulrst_prod_hi", int'(out_prod_hi), 0);
    chk("mulrst_zero", int'(out_zero), 1);
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("mulrst_no_stale_result", int'(saw_valid), 0);
    model_acc = 0;
    do_op(OP_NULL, 8'h99, 8'h00, 1'b1, 0, 9'h000, 8'h00);

    // random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = WIDTH'($urandom);
      rb  = (i % 9 == 0) ? '0 : WIDTH'($urandom);
      rua = 1'($urandom_range(0, 1));
      ea  = rua ? model_acc : int'(ra);
      ref_op(int'(rop), ea, int'(rb), r, h);
      do_op(rop, ra, rb, rua, $urandom_range(0, 2), (WIDTH + 1)'(r), WIDTH'(h));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational 8-bit ALU.
- Generic WIDTH datapath; valid/ready handshake on input and output.
- Internal accumulator, so results can chain without round-tripping through the register file.
- Adds a multi-cycle shift-add MUL op.
- Sits between operand fetch and writeback in the lab datapath; one op in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, MUL iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/opcode present.
- in_ready  output  1  block can accept; high only in IDLE.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- s_opcode  input  3  operation, encoding below.
- s_use_acc  input  1  1: operand A taken from accumulator instead of in_a.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH+1  bit WIDTH = carry/borrow/0; low bits = result (MUL: product low half).
- out_prod_hi  output  WIDTH  MUL product high half; 0 for all other ops.
- out_zero  output  1  low WIDTH bits of out_result == 0.

Behaviour:
- Opcodes: NULL=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOT=6, MUL=7.
- Operand A (opA) = s_use_acc ? acc : in_a.
- Arithmetic, all unsigned:
  - NULL: {0, opA}.
  - ADD: {0, opA} + {0, in_b}, full WIDTH+1 result.
  - SUB: ({0, opA} - {0, in_b}) mod 2^(WIDTH+1); bit WIDTH = 1 iff opA < in_b.
  - AND / OR / XOR: bitwise, bit WIDTH = 0.
  - NOT: {0, ~opA}; in_b ignored.
  - MUL: unsigned 2*WIDTH product; out_prod_hi = high half, out_result = {0, low half}.
- Accept: in_valid & in_ready at edge T latches opA, in_b, s_opcode. in_ready falls in cycle T+1.
- FSM states:
  - IDLE -> HOLD on accept of a non-MUL op (result registered at edge T, out_valid visible in cycle T+1; latency 1).
  - IDLE -> MUL on accept of MUL. Multiplicand/multiplier loaded, counter = 0.
  - MUL: per cycle, if multiplier LSB then add multiplicand into high partial; shift {hi, lo} right 1; counter++. After exactly WIDTH iterations -> HOLD. out_valid visible in cycle T+WIDTH+1.
  - HOLD: out_valid = 1; out_result, out_prod_hi, out_zero stable. out_valid & out_ready at an edge -> IDLE; in_ready high the next cycle. No same-cycle accept-while-holding.
- Accumulator: loaded with the low WIDTH bits of the result on entry to HOLD, independent of out_ready.
- in_valid with in_ready low is ignored: no queueing, inputs not sampled.
- out_ready outside HOLD has no effect.
- Reset, from any state including mid-MUL:
  - state = IDLE, acc = 0, counter = 0.
  - out_valid = 0, out_result = 0, out_prod_hi = 0.
  - out_zero = 1 (reflects out_result = 0).
  - in_ready = 1 in the first cycle after reset deassertion.
- Boundaries:
  - MUL by 0 still takes WIDTH cycles.
  - ADD overflow sets bit WIDTH, and acc wraps.
  - SUB equal operands gives 0 with out_zero = 1.
  - s_use_acc immediately after reset uses 0.
- All outputs are registered; no combinational path from inputs to outputs except in_ready (state decode only).

Decomposition:
- define_vars.v holds sOP_NULL..sOP_MUL (3-bit) and FSM state encodings ST_IDLE/ST_MUL/ST_HOLD.
- One sub-module: seq_multiplier (shift-add core).
  - Ports: clk, rst, start, a, b, busy, done, prod[2*WIDTH-1:0].
  - Parametrised by WIDTH.
- alu_pipe owns the handshake, the accumulator and the single-cycle ops.

Test Plan:
- WIDTH=8, ADD a=200 b=100 -> out_result 9'h12C, out_valid in cycle T+1, acc=8'h2C.
- SUB a=5 b=7 -> out_result 9'h1FE. Then SUB a=9 b=9 -> 9'h000 with out_zero=1.
- MUL a=255 b=255 -> out_prod_hi 8'hFE, out_result 9'h001, out_valid exactly 9 cycles after accept, in_ready low throughout.
- Chain:
  - ADD 10+20 -> 30.
  - Then ADD s_use_acc=1 b=5 -> 9'h023.
  - Then NOT s_use_acc=1 -> 9'h0DC.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after XOR 8'hF0^8'h3C -> out_valid and 9'h0CC stable all 5 cycles.
  - New in_valid during HOLD ignored.
  - in_ready high the cycle after out_ready.
- rst asserted at MUL iteration 4 -> next cycle: IDLE, in_ready=1, out_valid=0, out_result=0, acc=0. A following NULL with s_use_acc=1 -> 9'h000.
